// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_meter
//  Purpose  : Pulse-train receiver. Synchronizes an asynchronous input and
//             measures each complete pulse: high time and rising-to-rising
//             period in clock cycles. Also counts rising edges, flags closely
//             spaced pulses (bursts) and keeps a sticky counter-saturation flag.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock       in   single clock, rising edge active
//    reset_n     in   asynchronous active-low reset (deassertion synchronized)
//    signal      in   asynchronous pulse input under measurement
//    on          in   measurement enable; low forces IDLE
//    valid       out  one-cycle strobe: high_len/period_len updated
//    high_len    out  high time of last complete pulse [WIDTH]
//    period_len  out  rising-to-rising period of last pulse [WIDTH+1]
//    pulse_count out  rising edges seen while enabled, wraps [WIDTH]
//    burst       out  one-cycle strobe with valid when low time <= GAP_MAX
//    overflow    out  sticky: a high or low counter saturated
// ============================================================================
module pulse_meter #(
    parameter int WIDTH   = 8,
    parameter int GAP_MAX = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             signal,
    input  logic             on,
    output logic             valid,
    output logic [WIDTH-1:0] high_len,
    output logic [WIDTH:0]   period_len,
    output logic [WIDTH-1:0] pulse_count,
    output logic             burst,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] c_cnt_max = '1;
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [31:0]      c_gap_max = 32'(GAP_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    // Reset asserts asynchronously but releases on a clock edge, so no flop
    // leaves reset in the middle of a setup window.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // r_sync[1] is the synchronized level, r_sync[2] its one-cycle delay.
    logic [2:0] r_sync;
    logic       w_sig_s;
    logic       w_sig_d;
    logic       w_rise;
    logic       w_fall;

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], signal};
        end
    end

    assign w_sig_s = r_sync[1];
    assign w_sig_d = r_sync[2];
    assign w_rise  = w_sig_s & ~w_sig_d;
    assign w_fall  = ~w_sig_s & w_sig_d;

    state_t           r_state;
    logic [WIDTH-1:0] r_high_cnt;
    logic [WIDTH-1:0] r_low_cnt;
    logic [WIDTH-1:0] w_high_inc;
    logic [WIDTH-1:0] w_low_inc;
    logic [WIDTH:0]   w_period;
    logic [31:0]      w_low_ext;
    logic             w_burst_hit;

    // Saturating increments: counters park at all-ones. Reaching all-ones
    // means the reported value can no longer be trusted, hence overflow.
    assign w_high_inc  = (r_high_cnt == c_cnt_max) ? r_high_cnt : r_high_cnt + c_one;
    assign w_low_inc   = (r_low_cnt  == c_cnt_max) ? r_low_cnt  : r_low_cnt  + c_one;
    assign w_period    = {1'b0, r_high_cnt} + {1'b0, r_low_cnt};
    assign w_low_ext   = 32'(r_low_cnt);
    assign w_burst_hit = (w_low_ext <= c_gap_max);

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= S_IDLE;
            r_high_cnt  <= '0;
            r_low_cnt   <= '0;
            valid       <= 1'b0;
            burst       <= 1'b0;
            high_len    <= '0;
            period_len  <= '0;
            pulse_count <= '0;
            overflow    <= 1'b0;
        end else begin
            valid <= 1'b0;
            burst <= 1'b0;
            if (!on) begin
                // Disable abandons any partial measurement; results hold.
                r_state    <= S_IDLE;
                r_high_cnt <= '0;
                r_low_cnt  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_high_cnt <= '0;
                        r_low_cnt  <= '0;
                        // Only a fresh edge starts a measurement, so a level
                        // already high on entry is ignored until it cycles.
                        if (w_rise) begin
                            r_state     <= S_HIGH;
                            r_high_cnt  <= c_one;
                            pulse_count <= pulse_count + c_one;
                        end
                    end
                    S_HIGH: begin
                        if (w_fall) begin
                            r_state   <= S_LOW;
                            r_low_cnt <= c_one;
                        end else if (w_sig_s) begin
                            r_high_cnt <= w_high_inc;
                            if (w_high_inc == c_cnt_max) begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    S_LOW: begin
                        if (w_rise) begin
                            high_len    <= r_high_cnt;
                            period_len  <= w_period;
                            valid       <= 1'b1;
                            burst       <= w_burst_hit;
                            pulse_count <= pulse_count + c_one;
                            r_state     <= S_HIGH;
                            r_high_cnt  <= c_one;
                            r_low_cnt   <= '0;
                        end else if (!w_sig_s) begin
                            r_low_cnt <= w_low_inc;
                            if (w_low_inc == c_cnt_max) begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pulse_meter
//  Purpose  : Directed scoreboard bench for pulse_meter. Instance a uses the
//             default parameters, instance b uses WIDTH=4 for saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_meter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    logic sig_a, on_a, sig_b, on_b;

    logic       valid_a, burst_a, overflow_a;
    logic [7:0] high_len_a, pulse_count_a;
    logic [8:0] period_len_a;

    logic       valid_b, burst_b, overflow_b;
    logic [3:0] high_len_b, pulse_count_b;
    logic [4:0] period_len_b;

    pulse_meter #(.WIDTH(8), .GAP_MAX(4)) u_dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .signal      (sig_a),
        .on          (on_a),
        .valid       (valid_a),
        .high_len    (high_len_a),
        .period_len  (period_len_a),
        .pulse_count (pulse_count_a),
        .burst       (burst_a),
        .overflow    (overflow_a)
    );

    pulse_meter #(.WIDTH(4), .GAP_MAX(4)) u_dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .signal      (sig_b),
        .on          (on_b),
        .valid       (valid_b),
        .high_len    (high_len_b),
        .period_len  (period_len_b),
        .pulse_count (pulse_count_b),
        .burst       (burst_b),
        .overflow    (overflow_b)
    );

    typedef struct {
        int high;
        int period;
        int burst;
        int gap;    // cycles since previous valid; 0 = not checked
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_a(input int h, input int p, input int b, input int g);
        exp_t e;
        e.high = h; e.period = p; e.burst = b; e.gap = g;
        q_a.push_back(e);
    endfunction

    function automatic void push_b(input int h, input int p, input int b, input int g);
        exp_t e;
        e.high = h; e.period = p; e.burst = b; e.gap = g;
        q_b.push_back(e);
    endfunction

    // Monitors: pop an expectation for every valid strobe.
    int   last_a = 0;
    exp_t ea;
    always @(negedge clock) begin
        if (burst_a && !valid_a) chk("burst_a_alone", 64'(burst_a), 64'd0);
        if (valid_a) begin
            if (q_a.size() == 0) begin
                chk("unexpected_valid_a", 64'(valid_a), 64'd0);
            end else begin
                ea = q_a.pop_front();
                chk("high_len_a",   64'(high_len_a),   64'(ea.high));
                chk("period_len_a", 64'(period_len_a), 64'(ea.period));
                chk("burst_a",      64'(burst_a),      64'(ea.burst));
                if (ea.gap > 0) chk("valid_gap_a", 64'(cyc - last_a), 64'(ea.gap));
            end
            last_a = cyc;
        end
    end

    exp_t eb;
    always @(negedge clock) begin
        if (burst_b && !valid_b) chk("burst_b_alone", 64'(burst_b), 64'd0);
        if (valid_b) begin
            if (q_b.size() == 0) begin
                chk("unexpected_valid_b", 64'(valid_b), 64'd0);
            end else begin
                eb = q_b.pop_front();
                chk("high_len_b",   64'(high_len_b),   64'(eb.high));
                chk("period_len_b", 64'(period_len_b), 64'(eb.period));
                chk("burst_b",      64'(burst_b),      64'(eb.burst));
            end
        end
    end

    // Hold a signal level for n sampled cycles.
    task automatic drv(input bit sel_b, input bit lvl, input int n);
        repeat (n) begin
            if (sel_b) sig_b = lvl;
            else       sig_a = lvl;
            @(posedge clock);
            #1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drop and re-raise enable on instance a to return it to IDLE.
    task automatic quiesce();
        on_a = 1'b0;
        cycles(2);
        on_a = 1'b1;
        cycles(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        sig_a = 1'b0; on_a = 1'b0;
        sig_b = 1'b0; on_b = 1'b0;
        cycles(3);

        // Reset state
        chk("rst_valid",       64'(valid_a),       64'd0);
        chk("rst_high_len",    64'(high_len_a),    64'd0);
        chk("rst_period_len",  64'(period_len_a),  64'd0);
        chk("rst_pulse_count", 64'(pulse_count_a), 64'd0);
        chk("rst_burst",       64'(burst_a),       64'd0);
        chk("rst_overflow",    64'(overflow_a),    64'd0);

        reset_n = 1'b1;
        cycles(4);
        on_a = 1'b1;
        on_b = 1'b1;
        cycles(2);

        // High 3 / low 5, four periods
        for (int i = 0; i < 4; i++) begin
            if (i > 0) push_a(3, 8, 0, (i == 1) ? 0 : 8);
            drv(1'b0, 1'b1, 3);
            drv(1'b0, 1'b0, 5);
        end
        chk("t1_queue_empty", 64'(q_a.size()), 64'd0);
        chk("t1_pulse_count", 64'(pulse_count_a), 64'd4);

        // Burst window: low 2 is a burst, low 20 is not
        quiesce();
        drv(1'b0, 1'b1, 2);
        drv(1'b0, 1'b0, 2);
        push_a(2, 4, 1, 0);
        drv(1'b0, 1'b1, 2);
        drv(1'b0, 1'b0, 20);
        push_a(2, 22, 0, 0);
        drv(1'b0, 1'b1, 2);
        drv(1'b0, 1'b0, 3);
        chk("t2_queue_empty", 64'(q_a.size()), 64'd0);
        chk("t2_pulse_count", 64'(pulse_count_a), 64'd7);

        // Enable dropped mid-HIGH, signal toggles, enable raised while high
        quiesce();
        drv(1'b0, 1'b1, 3);
        drv(1'b0, 1'b0, 6);
        push_a(3, 9, 0, 0);
        drv(1'b0, 1'b1, 4);
        on_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b0, 1);
            drv(1'b0, 1'b1, 1);
        end
        drv(1'b0, 1'b1, 3);
        chk("off_queue_empty", 64'(q_a.size()),   64'd0);
        chk("off_high_len",    64'(high_len_a),   64'd3);
        chk("off_period_len",  64'(period_len_a), 64'd9);
        chk("off_pulse_count", 64'(pulse_count_a), 64'd9);
        on_a = 1'b1;
        drv(1'b0, 1'b1, 4);
        chk("on_high_pulse_count", 64'(pulse_count_a), 64'd9);
        chk("on_high_high_len",    64'(high_len_a),    64'd3);
        drv(1'b0, 1'b0, 2);
        drv(1'b0, 1'b1, 2);
        drv(1'b0, 1'b0, 3);
        push_a(2, 5, 1, 0);
        drv(1'b0, 1'b1, 1);
        drv(1'b0, 1'b0, 4);
        chk("t3_queue_empty", 64'(q_a.size()), 64'd0);
        chk("t3_pulse_count", 64'(pulse_count_a), 64'd11);

        // 1-high / 1-low square wave
        quiesce();
        drv(1'b0, 1'b1, 1);
        drv(1'b0, 1'b0, 1);
        for (int i = 0; i < 6; i++) begin
            push_a(1, 2, 1, (i == 0) ? 0 : 2);
            drv(1'b0, 1'b1, 1);
            drv(1'b0, 1'b0, 1);
        end
        drv(1'b0, 1'b0, 4);
        chk("sq_queue_empty", 64'(q_a.size()), 64'd0);
        chk("sq_pulse_count", 64'(pulse_count_a), 64'd18);

        // WIDTH=4 saturation: high 20, low 3
        drv(1'b1, 1'b1, 20);
        drv(1'b1, 1'b0, 3);
        push_b(15, 18, 1, 0);
        drv(1'b1, 1'b1, 2);
        drv(1'b1, 1'b0, 4);
        chk("sat_queue_empty", 64'(q_b.size()),     64'd0);
        chk("sat_overflow",    64'(overflow_b),     64'd1);
        chk("sat_pulse_count", 64'(pulse_count_b),  64'd2);
        drv(1'b1, 1'b0, 5);
        chk("sat_overflow_sticky", 64'(overflow_b), 64'd1);
        chk("a_no_overflow",       64'(overflow_a), 64'd0);

        // Asynchronous reset mid-LOW
        quiesce();
        drv(1'b0, 1'b1, 3);
        drv(1'b0, 1'b0, 5);
        chk("pre_rst_pulse_count", 64'(pulse_count_a), 64'd19);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid",       64'(valid_a),       64'd0);
        chk("arst_high_len",    64'(high_len_a),    64'd0);
        chk("arst_period_len",  64'(period_len_a),  64'd0);
        chk("arst_pulse_count", 64'(pulse_count_a), 64'd0);
        chk("arst_burst",       64'(burst_a),       64'd0);
        chk("arst_overflow_b",  64'(overflow_b),    64'd0);
        chk("arst_pulse_count_b", 64'(pulse_count_b), 64'd0);
        #22;
        reset_n = 1'b1;
        cycles(4);
        drv(1'b0, 1'b1, 2);
        drv(1'b0, 1'b0, 4);
        push_a(2, 6, 1, 0);
        drv(1'b0, 1'b1, 1);
        drv(1'b0, 1'b0, 4);
        chk("t5_queue_empty", 64'(q_a.size()), 64'd0);
        chk("t5_pulse_count", 64'(pulse_count_a), 64'd2);

        cycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_meter.md
# pulse_meter

Synchronous pulse-train receiver for the clock/pulse/signal-generator test environment. It samples an asynchronous `signal` input and measures each complete pulse: high time and rising-to-rising period, both in clock cycles. It also counts rising edges and flags closely spaced double pulses (bursts). It consumes the waveforms produced by the team's pulse and gated-signal generators and turns them into registered, checkable numbers.

## Interface
- `WIDTH`, 8: width of the high/low cycle counters and `pulse_count`.
- `GAP_MAX`, 4: maximum low time, in cycles, between two pulses for the second pulse to count as a burst.
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `signal` input 1: asynchronous pulse input under measurement.
- `on` input 1: measurement enable, synchronous; low forces IDLE.
- `valid` output 1: one-cycle strobe; `high_len` and `period_len` were updated this cycle.
- `high_len` output WIDTH: high time of the last complete pulse, in cycles.
- `period_len` output WIDTH+1: rising-to-rising period of the last complete pulse, in cycles.
- `pulse_count` output WIDTH: rising edges seen while enabled; wraps modulo 2^WIDTH.
- `burst` output 1: one-cycle strobe, coincident with `valid`, when the preceding low time was ≤ GAP_MAX.
- `overflow` output 1: sticky; set when any high or low counter saturated.

## Operation
- Input path:
  - 2-flop synchronizer produces `sig_s`.
  - A third flop produces `sig_d`.
  - `rise` = `sig_s & ~sig_d`; `fall` = `~sig_s & sig_d`.
- FSM states: IDLE, HIGH, LOW.
- IDLE:
  - Counters are held at 0.
  - On `on` & `rise`: go to HIGH, set `high_cnt`=1, increment `pulse_count`, no `valid`.
  - If `signal` is already high when entering IDLE, wait for a fresh `rise`.
- HIGH:
  - Increment `high_cnt` each cycle `sig_s`=1.
  - On `fall`: go to LOW, set `low_cnt`=1.
- LOW:
  - Increment `low_cnt` each cycle `sig_s`=0.
  - On `rise`:
    - Register `high_len`=`high_cnt` and `period_len`=`high_cnt`+`low_cnt` (computed at WIDTH+1 bits, no truncation).
    - Assert `valid`; assert `burst` if `low_cnt` ≤ GAP_MAX.
    - Increment `pulse_count`.
    - Go to HIGH with `high_cnt`=1, `low_cnt`=0.
- Saturation:
  - `high_cnt` and `low_cnt` stop at 2^WIDTH−1 and set `overflow`.
  - A measurement taken from a saturated counter is still reported, with the saturated value.
- `on` low, any state:
  - Next state is IDLE and counters clear.
  - `high_len`, `period_len` and `pulse_count` hold.
  - `valid` and `burst` stay low.
  - A `rise` in the same cycle as `on` low is ignored.
- `overflow` clears only on reset.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE; synchronizer, counters and all outputs are 0.
- Reset deassertion is synchronized internally, so the first active edge follows `reset_n` high by ≥1 cycle.
- Latency: a `signal` rising edge first sampled high at clock edge N asserts `valid` after edge N+2, for exactly one cycle.
- Measurement counts are sampled cycles:
  - `signal` high for H sampled cycles, then low for L → `high_len`=H, `period_len`=H+L.
  - Minimum measurable pulse: H=1, L=1.
- Pulses shorter than one clock period may be missed. This is not an error and is not flagged.
- Reset mid-HIGH or mid-LOW: the partial measurement is discarded, no `valid` is produced, and outputs go to 0 immediately.
- `burst` never asserts without `valid`.
- `pulse_count` wraps from 2^WIDTH−1 to 0 without setting `overflow`.

## Test plan
- Reset then `on`=1; `signal` repeats high 3 / low 5 cycles, 4 periods → first rise produces no `valid`; then 3 `valid` strobes, 8 cycles apart, each with `high_len`=3, `period_len`=8, `burst`=0; `pulse_count`=4.
- GAP_MAX=4; `signal` high 2 / low 2 / high 2 / low 20 / high 2 → at the second rise `valid`=1, `burst`=1, `period_len`=4; at the third rise `valid`=1, `burst`=0, `period_len`=22.
- WIDTH=4; `signal` high 20 cycles, then low 3, then rise → `high_len`=15, `period_len`=18, `overflow`=1 and it stays 1 afterwards.
- `on` dropped mid-HIGH, `signal` keeps toggling for 10 cycles, `on` raised with `signal` high → no `valid` while `on`=0 or before the next fresh rise; outputs hold their prior values.
- `reset_n` pulsed low mid-LOW, asynchronous to `clock` → all outputs 0 immediately; the next first rise produces no `valid`; the following rise yields a correct measurement.
- 1-cycle-high / 1-cycle-low square wave → `valid` every 2 cycles with `high_len`=1, `period_len`=2, and `burst`=1 when GAP_MAX ≥ 1.
